vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, max cycles from grant to vram_ack_i (0 = timeout disabled).
REQ-002 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have, for N=0 (rasterizer) and N=1 (display fetch), port mN_sel_i  input  1  request, held high until ack/err.
REQ-005 SHALL have ports mN_wr_i  input  1  write strobe; mN_mask_i  input  4  byte-lane mask; mN_addr_i  input  32  address; mN_data_i  input  16  write data.
REQ-006 SHALL have ports mN_ack_o  output  1  completion pulse; mN_err_o  output  1  timeout pulse; mN_data_o  output  16  read data.
REQ-007 SHALL have ports vram_sel_o  output  1; vram_wr_o  output  1; vram_mask_o  output  4; vram_addr_o  output  32; vram_data_out_o  output  16; all registered.
REQ-008 SHALL have ports vram_ack_i  input  1  memory completion; vram_data_in_i  input  16  read data.
REQ-009 SHALL have port grant_o  output  2  one-hot current owner (bit N = master N), 0 when idle.

Function
REQ-010 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE, one transaction per grant.
REQ-011 In IDLE, with any mN_sel_i high, SHALL register owner, latch owner's wr/mask/addr/data into vram_* and assert vram_sel_o on the next cycle (1-cycle request latency), entering BUSY.
REQ-012 Both masters requesting in IDLE SHALL resolve round-robin: grant the master not granted last; after reset the last-grant pointer = 1 (master 0 wins first tie).
REQ-013 In BUSY, vram_* outputs SHALL hold stable; changes on mN_* inputs SHALL be ignored.
REQ-014 On vram_ack_i high in BUSY, SHALL assert owner's mN_ack_o combinationally in that same cycle, drive mN_data_o = vram_data_in_i that cycle, deassert vram_sel_o next cycle, enter DONE.
REQ-015 Non-owner mN_ack_o/mN_err_o SHALL stay 0; non-owner mN_data_o SHALL be 0.
REQ-016 DONE SHALL last exactly 1 cycle with no arbitration (masters drop sel in this cycle), then IDLE; min spacing between vram_sel_o pulses = 2 idle cycles.
REQ-017 Timeout counter (10+ bits) SHALL clear on entering BUSY, increment each BUSY cycle without vram_ack_i; on reaching TIMEOUT_CYCLES, SHALL pulse owner's mN_err_o 1 cycle, drop vram_sel_o next cycle, enter DONE.
REQ-018 vram_ack_i and timeout in same cycle SHALL resolve as ack (no err).
REQ-019 vram_ack_i outside BUSY SHALL be ignored (no mN_ack_o).
REQ-020 grant_o SHALL be owner one-hot in BUSY and DONE, 0 in IDLE.
REQ-021 Pointer SHALL update to the granted master at each grant, irrespective of ack or timeout outcome.

Reset
REQ-022 reset_ni low SHALL immediately force IDLE, counter 0, pointer 1, all outputs 0, including mid-transaction (BUSY transaction abandoned, no ack/err issued).
REQ-023 After reset_ni rises, first arbitration SHALL occur on the first rising edge with reset_ni high.

Verification
REQ-024 Single write: m0 sel, wr=1, mask=4'hF, addr=0x100, data=0xABCD, ack 3 cycles after vram_sel_o -> vram_* match next cycle, m0_ack_o 1-cycle pulse coincident with vram_ack_i, grant_o 01->00.
REQ-025 Read: m1 read addr=0x200, vram_data_in_i=0x1234 with ack -> m1_data_o=0x1234 during m1_ack_o, m0 outputs 0.
REQ-026 Contention: m0 and m1 request continuously from reset, ack 1 cycle after sel -> grants alternate 0,1,0,1; vram_sel_o pulses separated by 2 cycles.
REQ-027 Timeout: TIMEOUT_CYCLES=8, m0 request, no ack -> m0_err_o pulse 8 BUSY cycles after grant, no m0_ack_o, IDLE 2 cycles later.
REQ-028 Reset mid-op: reset_ni low 2 cycles into BUSY -> all outputs 0 asynchronously; late vram_ack_i after release ignored; next tie grants m0.
REQ-029 Ack/timeout coincidence: TIMEOUT_CYCLES=4, ack on 4th BUSY cycle -> m0_ack_o pulse, m0_err_o stays 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port VRAM.
// One transaction per grant, with an optional per-transaction timeout.
module vram_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset_ni,

    input  logic        m0_sel_i,
    input  logic        m0_wr_i,
    input  logic [3:0]  m0_mask_i,
    input  logic [31:0] m0_addr_i,
    input  logic [15:0] m0_data_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [15:0] m0_data_o,

    input  logic        m1_sel_i,
    input  logic        m1_wr_i,
    input  logic [3:0]  m1_mask_i,
    input  logic [31:0] m1_addr_i,
    input  logic [15:0] m1_data_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [15:0] m1_data_o,

    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_mask_o,
    output logic [31:0] vram_addr_o,
    output logic [15:0] vram_data_out_o,
    input  logic        vram_ack_i,
    input  logic [15:0] vram_data_in_i,

    output logic [1:0]  grant_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1023) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 10;
    localparam logic          TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ?
                                        CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic [CW-1:0] r_cnt;

    logic        w_busy;
    logic        w_ack;
    logic        w_tout;
    logic        w_req;
    logic        w_pick;
    logic        w_wr;
    logic [3:0]  w_mask;
    logic [31:0] w_addr;
    logic [15:0] w_data;

    assign w_busy = (r_state == S_BUSY);
    assign w_ack  = w_busy & vram_ack_i;
    // Ack wins when it lands on the final allowed cycle.
    assign w_tout = w_busy & TO_EN & (r_cnt == TO_LAST) & ~vram_ack_i;

    assign w_req  = m0_sel_i | m1_sel_i;
    assign w_pick = (m0_sel_i & m1_sel_i) ? ~r_last : m1_sel_i;

    assign w_wr   = w_pick ? m1_wr_i   : m0_wr_i;
    assign w_mask = w_pick ? m1_mask_i : m0_mask_i;
    assign w_addr = w_pick ? m1_addr_i : m0_addr_i;
    assign w_data = w_pick ? m1_data_i : m0_data_i;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state         <= S_IDLE;
            r_owner         <= 1'b0;
            r_last          <= 1'b1;
            r_cnt           <= '0;
            vram_sel_o      <= 1'b0;
            vram_wr_o       <= 1'b0;
            vram_mask_o     <= '0;
            vram_addr_o     <= '0;
            vram_data_out_o <= '0;
            grant_o         <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_owner         <= w_pick;
                        r_last          <= w_pick;
                        r_cnt           <= '0;
                        vram_sel_o      <= 1'b1;
                        vram_wr_o       <= w_wr;
                        vram_mask_o     <= w_mask;
                        vram_addr_o     <= w_addr;
                        vram_data_out_o <= w_data;
                        grant_o         <= w_pick ? 2'b10 : 2'b01;
                        r_state         <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_ack | w_tout) begin
                        vram_sel_o <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    grant_o <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_ack_o  = w_ack & ~r_owner;
    assign m1_ack_o  = w_ack &  r_owner;
    assign m0_err_o  = w_tout & ~r_owner;
    assign m1_err_o  = w_tout &  r_owner;
    assign m0_data_o = m0_ack_o ? vram_data_in_i : '0;
    assign m1_data_o = m1_ack_o ? vram_data_in_i : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed cycle-vector bench for vram_arbiter.
// Two instances: timeout 8 (main) and timeout 4 (ack/timeout overlap).
module tb_vram_arbiter;

    typedef struct {
        logic        s0;
        logic        s1;
        logic        alt;
        logic        ack;
        logic [15:0] din;
        logic        vs;
        logic [1:0]  g;
        logic        a0;
        logic        a1;
        logic        e0;
        logic        e1;
        logic [15:0] d0;
        logic [15:0] d1;
    } vec_t;

    localparam int NV = 36;
    localparam int TO_START = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_sel, m0_wr, m1_sel, m1_wr;
    logic [3:0]  m0_mask, m1_mask;
    logic [31:0] m0_addr, m1_addr;
    logic [15:0] m0_data, m1_data;
    logic        vack;
    logic [15:0] vdin;

    logic        a0, e0, a1, e1, vsel, vwr;
    logic [15:0] d0, d1, vdout;
    logic [3:0]  vmask;
    logic [31:0] vaddr;
    logic [1:0]  grant;

    logic        b_a0, b_e0, b_a1, b_e1, b_vsel, b_vwr;
    logic [15:0] b_d0, b_d1, b_vdout;
    logic [3:0]  b_vmask;
    logic [31:0] b_vaddr;
    logic [1:0]  b_grant;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tv [NV];

    vram_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .reset_ni(rst_n),
        .m0_sel_i(m0_sel), .m0_wr_i(m0_wr), .m0_mask_i(m0_mask),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data),
        .m0_ack_o(a0), .m0_err_o(e0), .m0_data_o(d0),
        .m1_sel_i(m1_sel), .m1_wr_i(m1_wr), .m1_mask_i(m1_mask),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data),
        .m1_ack_o(a1), .m1_err_o(e1), .m1_data_o(d1),
        .vram_sel_o(vsel), .vram_wr_o(vwr), .vram_mask_o(vmask),
        .vram_addr_o(vaddr), .vram_data_out_o(vdout),
        .vram_ack_i(vack), .vram_data_in_i(vdin),
        .grant_o(grant)
    );

    vram_arbiter #(.TIMEOUT_CYCLES(4)) u_dut4 (
        .clk(clk), .reset_ni(rst_n),
        .m0_sel_i(m0_sel), .m0_wr_i(m0_wr), .m0_mask_i(m0_mask),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data),
        .m0_ack_o(b_a0), .m0_err_o(b_e0), .m0_data_o(b_d0),
        .m1_sel_i(m1_sel), .m1_wr_i(m1_wr), .m1_mask_i(m1_mask),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data),
        .m1_ack_o(b_a1), .m1_err_o(b_e1), .m1_data_o(b_d1),
        .vram_sel_o(b_vsel), .vram_wr_o(b_vwr), .vram_mask_o(b_vmask),
        .vram_addr_o(b_vaddr), .vram_data_out_o(b_vdout),
        .vram_ack_i(vack), .vram_data_in_i(vdin),
        .grant_o(b_grant)
    );

    function automatic vec_t v(
        input logic s0, input logic s1, input logic alt,
        input logic ack, input logic [15:0] din,
        input logic vs, input logic [1:0] g,
        input logic xa0, input logic xa1,
        input logic xe0, input logic xe1,
        input logic [15:0] xd0, input logic [15:0] xd1);
        vec_t t;
        t.s0 = s0;   t.s1 = s1;   t.alt = alt;
        t.ack = ack; t.din = din; t.vs = vs;
        t.g = g;     t.a0 = xa0;  t.a1 = xa1;
        t.e0 = xe0;  t.e1 = xe1;  t.d0 = xd0;
        t.d1 = xd1;
        return t;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        m0_sel = t.s0;
        m1_sel = t.s1;
        vack   = t.ack;
        vdin   = t.din;
        if (t.alt) begin
            m0_wr   = 1'b0;
            m0_mask = 4'h0;
            m0_addr = 32'h999;
            m0_data = 16'h0000;
        end else begin
            m0_wr   = 1'b1;
            m0_mask = 4'hF;
            m0_addr = 32'h100;
            m0_data = 16'hABCD;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // write: ack on 4th busy cycle, m0 payload wiggled while busy
        tv[0]  = v(1,0,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        tv[1]  = v(1,0,0,0,16'h0,    1,2'b01,0,0,0,0,16'h0,16'h0);
        tv[2]  = v(1,0,1,0,16'h0,    1,2'b01,0,0,0,0,16'h0,16'h0);
        tv[3]  = v(1,0,1,0,16'h0,    1,2'b01,0,0,0,0,16'h0,16'h0);
        tv[4]  = v(1,0,0,1,16'hC0DE, 1,2'b01,1,0,0,0,16'hC0DE,16'h0);
        tv[5]  = v(0,0,0,0,16'h0,    0,2'b01,0,0,0,0,16'h0,16'h0);
        tv[6]  = v(0,0,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        // m1 read, then a stray ack while idle
        tv[7]  = v(0,1,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        tv[8]  = v(0,1,0,0,16'h0,    1,2'b10,0,0,0,0,16'h0,16'h0);
        tv[9]  = v(0,1,0,1,16'h1234, 1,2'b10,0,1,0,0,16'h0,16'h1234);
        tv[10] = v(0,0,0,0,16'h0,    0,2'b10,0,0,0,0,16'h0,16'h0);
        tv[11] = v(0,0,0,1,16'h5555, 0,2'b00,0,0,0,0,16'h0,16'h0);
        // contention: both request continuously
        tv[12] = v(1,1,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        tv[13] = v(1,1,0,0,16'h0,    1,2'b01,0,0,0,0,16'h0,16'h0);
        tv[14] = v(1,1,0,1,16'h00AA, 1,2'b01,1,0,0,0,16'h00AA,16'h0);
        tv[15] = v(1,1,0,0,16'h0,    0,2'b01,0,0,0,0,16'h0,16'h0);
        tv[16] = v(1,1,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        tv[17] = v(1,1,0,0,16'h0,    1,2'b10,0,0,0,0,16'h0,16'h0);
        tv[18] = v(1,1,0,1,16'h0BEE, 1,2'b10,0,1,0,0,16'h0,16'h0BEE);
        tv[19] = v(1,1,0,0,16'h0,    0,2'b10,0,0,0,0,16'h0,16'h0);
        tv[20] = v(1,1,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        tv[21] = v(1,1,0,0,16'h0,    1,2'b01,0,0,0,0,16'h0,16'h0);
        tv[22] = v(1,1,0,1,16'h0,    1,2'b01,1,0,0,0,16'h0,16'h0);
        tv[23] = v(0,0,0,0,16'h0,    0,2'b01,0,0,0,0,16'h0,16'h0);
        tv[24] = v(0,0,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        // timeout: no ack, err on 8th busy cycle
        tv[25] = v(1,0,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);
        for (int k = 26; k < 33; k++)
            tv[k] = v(1,0,0,0,16'h0, 1,2'b01,0,0,0,0,16'h0,16'h0);
        tv[33] = v(1,0,0,0,16'h0,    1,2'b01,0,0,1,0,16'h0,16'h0);
        tv[34] = v(0,0,0,0,16'h0,    0,2'b01,0,0,0,0,16'h0,16'h0);
        tv[35] = v(0,0,0,0,16'h0,    0,2'b00,0,0,0,0,16'h0,16'h0);

        m1_wr   = 1'b0;
        m1_mask = 4'h3;
        m1_addr = 32'h200;
        m1_data = 16'h5A5A;
        drive(v(1,0,0,1,16'h7777,0,2'b00,0,0,0,0,16'h0,16'h0));
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vsel",  {31'b0, vsel},  32'h0);
        chk("rst_grant", {30'b0, grant}, 32'h0);
        chk("rst_ack0",  {31'b0, a0},    32'h0);
        chk("rst_addr",  vaddr,          32'h0);
        chk("rst_wdata", {16'h0, vdout}, 32'h0);
        chk("rst_data0", {16'h0, d0},    32'h0);
        drive(v(0,0,0,0,16'h0,0,2'b00,0,0,0,0,16'h0,16'h0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("v%0d_vsel", i),  {31'b0, vsel},  {31'b0, tv[i].vs});
            chk($sformatf("v%0d_grant", i), {30'b0, grant}, {30'b0, tv[i].g});
            chk($sformatf("v%0d_ack0", i),  {31'b0, a0},    {31'b0, tv[i].a0});
            chk($sformatf("v%0d_ack1", i),  {31'b0, a1},    {31'b0, tv[i].a1});
            chk($sformatf("v%0d_err0", i),  {31'b0, e0},    {31'b0, tv[i].e0});
            chk($sformatf("v%0d_err1", i),  {31'b0, e1},    {31'b0, tv[i].e1});
            chk($sformatf("v%0d_data0", i), {16'h0, d0},    {16'h0, tv[i].d0});
            chk($sformatf("v%0d_data1", i), {16'h0, d1},    {16'h0, tv[i].d1});
            if (tv[i].vs) begin
                if (tv[i].g == 2'b01) begin
                    chk($sformatf("v%0d_addr", i), vaddr, 32'h100);
                    chk($sformatf("v%0d_wdat", i), {16'h0, vdout}, 32'hABCD);
                    chk($sformatf("v%0d_wr", i), {31'b0, vwr}, 32'h1);
                    chk($sformatf("v%0d_mask", i), {28'b0, vmask}, 32'hF);
                end else begin
                    chk($sformatf("v%0d_addr", i), vaddr, 32'h200);
                    chk($sformatf("v%0d_wdat", i), {16'h0, vdout}, 32'h5A5A);
                    chk($sformatf("v%0d_wr", i), {31'b0, vwr}, 32'h0);
                    chk($sformatf("v%0d_mask", i), {28'b0, vmask}, 32'h3);
                end
            end
            if (i < TO_START) begin
                chk($sformatf("t4_v%0d_ack0", i), {31'b0, b_a0},
                    {31'b0, tv[i].a0});
                chk($sformatf("t4_v%0d_err0", i), {31'b0, b_e0}, 32'h0);
                chk($sformatf("t4_v%0d_grant", i), {30'b0, b_grant},
                    {30'b0, tv[i].g});
            end
        end

        // reset two cycles into busy
        @(posedge clk);
        #1;
        drive(v(1,0,0,0,16'h0,0,2'b00,0,0,0,0,16'h0,16'h0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_grant_pre", {30'b0, grant}, 32'h1);
        rst_n = 1'b0;
        vack  = 1'b1;
        vdin  = 16'hDEAD;
        #1;
        chk("mid_vsel",  {31'b0, vsel},  32'h0);
        chk("mid_grant", {30'b0, grant}, 32'h0);
        chk("mid_addr",  vaddr,          32'h0);
        chk("mid_mask",  {28'b0, vmask}, 32'h0);
        chk("mid_wr",    {31'b0, vwr},   32'h0);
        chk("mid_ack0",  {31'b0, a0},    32'h0);
        chk("mid_err0",  {31'b0, e0},    32'h0);
        chk("mid_data0", {16'h0, d0},    32'h0);
        m0_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_hold_grant", {30'b0, grant}, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        m0_sel = 1'b1;
        m1_sel = 1'b1;
        #1;
        chk("late_ack0",  {31'b0, a0}, 32'h0);
        chk("late_ack1",  {31'b0, a1}, 32'h0);
        chk("late_data0", {16'h0, d0}, 32'h0);
        vack = 1'b0;
        @(negedge clk);
        chk("post_grant", {30'b0, grant}, 32'h1);
        chk("post_vsel",  {31'b0, vsel},  32'h1);
        chk("post_addr",  vaddr,          32'h100);
        m0_sel = 1'b0;
        m1_sel = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
